// File: rtl/fpu_resp_model_if.sv
// Handshake bundle between the FPU stimulus driver and the FPU stand-in.
interface fpu_resp_model_if;
  logic        flush;
  logic        decode;
  logic        execute;
  logic [7:0]  fpuOp;
  logic [1:0]  rounding;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] fpuOut;
  logic        validarithmetic;
  logic        compare;
  logic        validcompare;
  logic [11:0] fpcsr;

  modport master (
    output flush, decode, execute, fpuOp, rounding, opA, opB,
    input  fpuOut, validarithmetic, compare, validcompare, fpcsr
  );

  modport slave (
    input  flush, decode, execute, fpuOp, rounding, opA, opB,
    output fpuOut, validarithmetic, compare, validcompare, fpcsr
  );
endinterface

// File: rtl/fpu_resp_model.sv
// FPU stand-in: latches operands on decode, runs a fixed-latency signature
// arithmetic path or an exact IEEE-754 single compare, holds results until
// the next decode or a flush.
module fpu_resp_model #(
  parameter int ARITH_LAT = 4,
  parameter int CMP_LAT   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  fpu_resp_model_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DEC, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opb_q;
  logic [7:0]  op_q;
  logic [1:0]  rm_q;
  logic [31:0] out_q;
  logic        cmp_q, va_q, vc_q;
  logic [8:0]  flags_q;          // fpcsr[11:3]

  // control strobes and path results
  logic        latch_en, done_en;
  logic [31:0] arith_out;
  logic [8:0]  arith_flags, cmp_flags;
  logic        cmp_res;
  logic        a_nan, b_nan, a_snan, b_snan, both_zero, eq, lt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: counter is loaded with the latency and the result lands on
  // the edge where it would reach zero, so valid rises LAT edges after execute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.decode) state_d = DEC;
        DEC: if (bus.execute) begin
          state_d = BUSY;
          cnt_d   = op_q[3] ? 4'(CMP_LAT) : 4'(ARITH_LAT);
        end
        BUSY: if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
        DONE: if (bus.decode) state_d = DEC;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath decode: strobes plus arithmetic and compare results
  always_comb begin
    // execute in DEC takes priority over a same-cycle re-decode
    latch_en = !bus.flush && bus.decode &&
               (state_q == IDLE || state_q == DONE || (state_q == DEC && !bus.execute));
    done_en  = !bus.flush && state_q == BUSY && cnt_q <= 4'd1;

    arith_out   = opa_q ^ {opb_q[15:0], opb_q[31:16]} ^ {24'h0, op_q};
    arith_flags = '0;
    if (op_q[2:0] == 3'd6 || op_q[2:0] == 3'd7) begin
      arith_out      = '0;
      arith_flags[6] = 1'b1;
    end else if (op_q[2:0] == 3'd3 && opb_q[30:0] == 31'h0) begin
      arith_flags[8] = 1'b1;
    end

    a_nan     = opa_q[30:23] == 8'hFF && opa_q[22:0] != 23'h0;
    b_nan     = opb_q[30:23] == 8'hFF && opb_q[22:0] != 23'h0;
    a_snan    = a_nan && !opa_q[22];
    b_snan    = b_nan && !opb_q[22];
    both_zero = opa_q[30:0] == 31'h0 && opb_q[30:0] == 31'h0;
    eq        = both_zero || opa_q == opb_q;
    if (opa_q[31] != opb_q[31]) lt = opa_q[31] && !both_zero;
    else if (!opa_q[31])        lt = opa_q[30:0] < opb_q[30:0];
    else                        lt = opa_q[30:0] > opb_q[30:0];

    cmp_flags = '0;
    case (op_q[2:0])
      3'd0:    cmp_res = eq;
      3'd1:    cmp_res = !eq;
      3'd2:    cmp_res = !eq && !lt;
      3'd3:    cmp_res = !lt;
      3'd4:    cmp_res = lt;
      3'd5:    cmp_res = lt || eq;
      default: begin
        cmp_res      = 1'b0;
        cmp_flags[6] = 1'b1;
      end
    endcase
    // unordered: only "ne" holds
    if (a_nan || b_nan) begin
      cmp_res      = (op_q[2:0] == 3'd1);
      cmp_flags[6] = 1'b1;
      cmp_flags[2] = a_snan || b_snan;
      cmp_flags[3] = (a_nan && !a_snan) || (b_nan && !b_snan);
    end
  end

  // Operand latches and registered results; flush clears results but keeps RM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      rm_q    <= '0;
      out_q   <= '0;
      cmp_q   <= 1'b0;
      va_q    <= 1'b0;
      vc_q    <= 1'b0;
      flags_q <= '0;
    end else if (bus.flush) begin
      out_q   <= '0;
      cmp_q   <= 1'b0;
      va_q    <= 1'b0;
      vc_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      if (latch_en) begin
        opa_q <= bus.opA;
        opb_q <= bus.opB;
        op_q  <= bus.fpuOp;
        rm_q  <= bus.rounding;
        va_q  <= 1'b0;
        vc_q  <= 1'b0;
      end
      if (done_en) begin
        if (op_q[3]) begin
          vc_q    <= 1'b1;
          cmp_q   <= cmp_res;
          out_q   <= '0;
          flags_q <= cmp_flags;
        end else begin
          va_q    <= 1'b1;
          cmp_q   <= 1'b0;
          out_q   <= arith_out;
          flags_q <= arith_flags;
        end
      end
    end
  end

  assign bus.fpuOut          = out_q;
  assign bus.compare         = cmp_q;
  assign bus.validarithmetic = va_q;
  assign bus.validcompare    = vc_q;
  assign bus.fpcsr           = {flags_q, rm_q, 1'b0};

endmodule

// File: tb/tb_fpu_resp_model.sv
// Directed bench for fpu_resp_model: a vector table for single operations
// plus hand-written flush/reset/hold sequences.
module tb_fpu_resp_model;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  fpu_resp_model_if bus ();
  fpu_resp_model #(.ARITH_LAT(4), .CMP_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_cmp;
    logic [11:0] exp_csr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.decode = 0; bus.execute = 0;
  endtask

  // decode + execute, then count posedges until the expected valid rises
  task automatic run_txn(input logic [7:0] op, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.decode = 1; bus.fpuOp = op; bus.rounding = rm; bus.opA = a; bus.opB = b;
    @(negedge clk);
    bus.decode = 0; bus.execute = 1;
    @(posedge clk); #1;
    bus.execute = 0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (op[3] ? bus.validcompare : bus.validarithmetic) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic no_valid_for(input string name, input int cycles);
    logic seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      seen = seen | bus.validarithmetic | bus.validcompare;
    end
    chk(name, {31'h0, seen}, 32'h0);
  endtask

  task automatic chk_clear(input string name, input logic [11:0] csr);
    chk({name, "_out"}, bus.fpuOut, 32'h0);
    chk({name, "_va"}, {31'h0, bus.validarithmetic}, 32'h0);
    chk({name, "_vc"}, {31'h0, bus.validcompare}, 32'h0);
    chk({name, "_cmp"}, {31'h0, bus.compare}, 32'h0);
    chk({name, "_csr"}, {20'h0, bus.fpcsr}, {20'h0, csr});
  endtask

  initial begin
    int lat;
    idle_inputs();
    bus.fpuOp = 0; bus.rounding = 0; bus.opA = 0; bus.opB = 0;

    vecs.push_back('{"add",      8'h00, 2'd0, 32'h3F800000, 32'h40000000, 32'h3F804000, 1'b0, 12'h000});
    vecs.push_back('{"sub",      8'h01, 2'd1, 32'h12345678, 32'h9ABCDEF0, 32'hCCC4CCC5, 1'b0, 12'h002});
    vecs.push_back('{"mul",      8'h02, 2'd3, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFD, 1'b0, 12'h006});
    vecs.push_back('{"div_dz",   8'h03, 2'd0, 32'h3F800000, 32'h80000000, 32'h3F808003, 1'b0, 12'h800});
    vecs.push_back('{"div_nz",   8'h03, 2'd0, 32'h00000000, 32'h00000001, 32'h00010003, 1'b0, 12'h000});
    vecs.push_back('{"itof_hi",  8'h14, 2'd0, 32'h00000000, 32'h00000000, 32'h00000014, 1'b0, 12'h000});
    vecs.push_back('{"arith_bad",8'h06, 2'd0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 12'h200});
    vecs.push_back('{"eq_zero",  8'h08, 2'd0, 32'h00000000, 32'h80000000, 32'h0, 1'b1, 12'h000});
    vecs.push_back('{"lt_qnan",  8'h0C, 2'd0, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b0, 12'h240});
    vecs.push_back('{"ne_qnan",  8'h09, 2'd0, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1, 12'h240});
    vecs.push_back('{"eq_snan",  8'h08, 2'd2, 32'h7F800001, 32'h00000000, 32'h0, 1'b0, 12'h224});
    vecs.push_back('{"gt_sign",  8'h0A, 2'd0, 32'h3F800000, 32'hBF800000, 32'h0, 1'b1, 12'h000});
    vecs.push_back('{"ge_neg",   8'h0B, 2'd0, 32'hC0000000, 32'hBF800000, 32'h0, 1'b0, 12'h000});
    vecs.push_back('{"le_neg",   8'h0D, 2'd0, 32'hC0000000, 32'hBF800000, 32'h0, 1'b1, 12'h000});
    vecs.push_back('{"lt_pos",   8'h0C, 2'd0, 32'h3F800000, 32'h40000000, 32'h0, 1'b1, 12'h000});
    vecs.push_back('{"ge_equal", 8'h0B, 2'd0, 32'h41200000, 32'h41200000, 32'h0, 1'b1, 12'h000});
    vecs.push_back('{"gt_zeros", 8'h0A, 2'd0, 32'h80000000, 32'h00000000, 32'h0, 1'b0, 12'h000});
    vecs.push_back('{"gt_inf",   8'h0A, 2'd0, 32'h7F800000, 32'h7F7FFFFF, 32'h0, 1'b1, 12'h000});
    vecs.push_back('{"cmp_bad",  8'h0E, 2'd0, 32'h3F800000, 32'h3F800000, 32'h0, 1'b0, 12'h200});

    // reset held 5 clocks
    repeat (5) @(posedge clk);
    #1;
    chk_clear("reset", 12'h000);
    @(negedge clk);
    reset_n = 1;

    // table: latency, result, other-path valid, fpcsr
    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].rm, vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].op[3] ? 32'd1 : 32'd4);
      chk({vecs[i].name, "_out"}, bus.fpuOut, vecs[i].exp_out);
      chk({vecs[i].name, "_csr"}, {20'h0, bus.fpcsr}, {20'h0, vecs[i].exp_csr});
      if (vecs[i].op[3]) begin
        chk({vecs[i].name, "_cmp"}, {31'h0, bus.compare}, {31'h0, vecs[i].exp_cmp});
        chk({vecs[i].name, "_va0"}, {31'h0, bus.validarithmetic}, 32'h0);
      end else begin
        chk({vecs[i].name, "_vc0"}, {31'h0, bus.validcompare}, 32'h0);
      end
    end

    // DONE holds, then decode drops the valid on the next edge
    run_txn(8'h02, 2'd0, 32'h0000FFFF, 32'h0, lat);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_va", {31'h0, bus.validarithmetic}, 32'h1);
    chk("hold_out", bus.fpuOut, 32'h0000FFFD);
    @(negedge clk);
    bus.decode = 1; bus.fpuOp = 8'h00;
    @(posedge clk); #1;
    bus.decode = 0;
    chk("redecode_drop", {31'h0, bus.validarithmetic}, 32'h0);

    // div by -0 then flush: results clear, RM kept, back in IDLE
    run_txn(8'h03, 2'd2, 32'h3F800000, 32'h80000000, lat);
    chk("dz_csr", {20'h0, bus.fpcsr}, 32'h804);
    @(negedge clk);
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    chk_clear("flush", 12'h004);
    @(negedge clk);
    bus.execute = 1;
    @(negedge clk);
    bus.execute = 0;
    no_valid_for("idle_exec_ignored", 8);

    // flush together with execute: the operation never starts
    @(negedge clk);
    bus.decode = 1; bus.fpuOp = 8'h00; bus.opA = 32'h1; bus.opB = 32'h0;
    @(negedge clk);
    bus.decode = 0; bus.execute = 1; bus.flush = 1;
    @(negedge clk);
    idle_inputs();
    no_valid_for("flush_exec", 8);
    run_txn(8'h00, 2'd0, 32'h3F800000, 32'h40000000, lat);
    chk("after_flush_lat", lat, 32'd4);
    chk("after_flush_out", bus.fpuOut, 32'h3F804000);

    // reset for 2 clocks in BUSY: immediate clear, later execute ignored
    @(negedge clk);
    bus.decode = 1; bus.fpuOp = 8'h01; bus.rounding = 2'd3;
    @(negedge clk);
    bus.decode = 0; bus.execute = 1;
    @(negedge clk);
    bus.execute = 0;
    @(negedge clk);
    reset_n = 0;
    #1;
    chk_clear("busy_reset", 12'h000);
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    bus.execute = 1;
    @(negedge clk);
    bus.execute = 0;
    no_valid_for("post_reset_exec", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
